// File: rtl/timer_bank.sv
// Bank of CHANNELS programmable down-counting timers sharing one prescaler.
// Latency: an enable written at edge t with period P raises pending after edge t+P*PRESCALE (PRESCALE=1).
// No backpressure: writes and acks are accepted every cycle; interrupts stay pending until acked.
//
// Ports:
//   clk, reset     - rising-edge clock, asynchronous active-high reset
//   wr_en/wr_sel   - register write strobe and target channel (sel >= CHANNELS is ignored)
//   wr_cfg/wr_data - 1: control write (bit0 enable, bit1 one-shot), 0: period write
//   ack            - per-channel clear of pending and overrun
//   interruptions  - pending[i] on bit IRQ_BASE+i, all other bits 0
//   overrun        - per-channel flag: expiry while still pending
module timer_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1,
  parameter int IRQ_BASE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [2:0]          wr_sel,
  input  logic                wr_cfg,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [CHANNELS-1:0] ack,
  output logic [7:0]          interruptions,
  output logic [CHANNELS-1:0] overrun
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]       presc_q, presc_d;
  logic                tick;

  logic [WIDTH-1:0]    period_q [CHANNELS];
  logic [WIDTH-1:0]    period_d [CHANNELS];
  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] mode_q, mode_d;     // 1 = one-shot
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] ovr_q, ovr_d;
  logic [CHANNELS-1:0] expire;
  logic [CHANNELS-1:0] sel_hit;

  // Free-running prescaler; runs regardless of channel enables.
  always_comb begin
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_comb begin
    expire  = '0;
    sel_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      // Only a counter sitting at 1 expires, so period 0 never fires.
      expire[i]  = tick && en_q[i] && (cnt_q[i] == WIDTH'(1));
      sel_hit[i] = wr_en && (wr_sel == 3'(i));
    end
  end

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    ovr_d    = ovr_q;
    for (int i = 0; i < CHANNELS; i++) begin
      // Counting: decrement, or reload/stop on expiry.
      if (tick && en_q[i]) begin
        if (cnt_q[i] > WIDTH'(1)) begin
          cnt_d[i] = cnt_q[i] - WIDTH'(1);
        end else if (expire[i]) begin
          if (mode_q[i]) begin
            cnt_d[i] = '0;
            en_d[i]  = 1'b0;
          end else begin
            cnt_d[i] = period_q[i];
          end
        end
      end

      // Expiry beats ack for pending; ack beats expiry for overrun.
      if (expire[i]) begin
        pend_d[i] = 1'b1;
      end else if (ack[i]) begin
        pend_d[i] = 1'b0;
      end
      if (ack[i]) begin
        ovr_d[i] = 1'b0;
      end else if (expire[i] && pend_q[i]) begin
        ovr_d[i] = 1'b1;
      end

      // Register writes override the counting result; pending is unaffected.
      if (sel_hit[i]) begin
        if (wr_cfg) begin
          en_d[i]   = wr_data[0];
          mode_d[i] = wr_data[1];
          if (wr_data[0] && (cnt_q[i] == '0)) begin
            cnt_d[i] = period_q[i];
          end
        end else begin
          period_d[i] = wr_data;
          cnt_d[i]    = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      period_q <= '{default: '0};
      cnt_q    <= '{default: '0};
      en_q     <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      ovr_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      ovr_q    <= ovr_d;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    interruptions = '0;
    interruptions[IRQ_BASE +: CHANNELS] = pend_q;
  end

  assign overrun = ovr_q;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  logic        clk;
  logic        reset;
  logic        wr_en_a, wr_en_b, wr_en_c;
  logic [2:0]  wr_sel;
  logic        wr_cfg;
  logic [15:0] wr_data;
  logic [3:0]  ack_a, ack_b, ack_c;
  logic [7:0]  irq_a, irq_b, irq_c;
  logic [3:0]  ovr_a, ovr_b, ovr_c;

  int checks = 0;
  int errors = 0;

  // a: base config, b: PRESCALE=4, c: IRQ_BASE=4
  timer_bank #(.CHANNELS(4), .WIDTH(16), .PRESCALE(1), .IRQ_BASE(0)) u_a (
    .clk(clk), .reset(reset), .wr_en(wr_en_a), .wr_sel(wr_sel), .wr_cfg(wr_cfg),
    .wr_data(wr_data), .ack(ack_a), .interruptions(irq_a), .overrun(ovr_a));

  timer_bank #(.CHANNELS(4), .WIDTH(16), .PRESCALE(4), .IRQ_BASE(0)) u_b (
    .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_sel(wr_sel), .wr_cfg(wr_cfg),
    .wr_data(wr_data), .ack(ack_b), .interruptions(irq_b), .overrun(ovr_b));

  timer_bank #(.CHANNELS(4), .WIDTH(16), .PRESCALE(1), .IRQ_BASE(4)) u_c (
    .clk(clk), .reset(reset), .wr_en(wr_en_c), .wr_sel(wr_sel), .wr_cfg(wr_cfg),
    .wr_data(wr_data), .ack(ack_c), .interruptions(irq_c), .overrun(ovr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write is taken on the next rising edge.
  task automatic wr(input int inst, input logic [2:0] sel, input logic cfg, input logic [15:0] d);
    wr_sel  = sel;
    wr_cfg  = cfg;
    wr_data = d;
    wr_en_a = (inst == 0);
    wr_en_b = (inst == 1);
    wr_en_c = (inst == 2);
    @(negedge clk);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
    wr_en_c = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Instance c: channel i enabled at edge 5+i with period 3+i, ack held high,
  // so bit 4+i is set exactly after each expiry edge.
  function automatic logic [7:0] exp_c(input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (n > 5 + i && ((n - 5 - i) % (3 + i)) == 0) r[4 + i] = 1'b1;
    end
    return r;
  endfunction

  initial begin
    reset   = 1'b1;
    wr_en_a = 1'b0; wr_en_b = 1'b0; wr_en_c = 1'b0;
    wr_sel  = '0; wr_cfg = 1'b0; wr_data = '0;
    ack_a   = '0; ack_b = '0; ack_c = '0;
    cyc(2);
    check("rst_irq", {24'h0, irq_a}, 32'h0);
    check("rst_ovr", {28'h0, ovr_a}, 32'h0);
    reset = 1'b0;

    // ---- periodic ch0, period 5 ----
    wr(0, 3'd0, 1'b0, 16'd5);
    wr(0, 3'd0, 1'b1, 16'h0001);          // enable at edge t
    check("per_t0", {24'h0, irq_a}, 32'h0);
    cyc(4);
    check("per_t4", {24'h0, irq_a}, 32'h0);
    cyc(1);
    check("per_t5", {24'h0, irq_a}, 32'h01);
    ack_a = 4'b0001; cyc(1); ack_a = '0;  // edge t+6
    check("per_ack", {24'h0, irq_a}, 32'h0);
    cyc(3);
    check("per_t9", {24'h0, irq_a}, 32'h0);
    cyc(1);
    check("per_t10", {24'h0, irq_a}, 32'h01);
    // ack landing on the expiry edge t+15
    cyc(4);
    ack_a = 4'b0001; cyc(1); ack_a = '0;
    check("ackexp_irq", {24'h0, irq_a}, 32'h01);
    check("ackexp_ovr", {28'h0, ovr_a}, 32'h0);
    cyc(5);                                // expiry t+20 without ack
    check("ovr_set", {28'h0, ovr_a}, 32'h1);
    check("ovr_irq", {24'h0, irq_a}, 32'h01);

    // ---- async reset mid-count (counter = 2 after t+23) ----
    cyc(3);
    #2 reset = 1'b1;
    #1;
    check("rst_async_irq", {24'h0, irq_a}, 32'h0);
    check("rst_async_ovr", {28'h0, ovr_a}, 32'h0);
    #9 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 50; k++) begin
      cyc(1);
      check("rst_quiet", {24'h0, irq_a}, 32'h0);
    end
    check("rst_quiet_ovr", {28'h0, ovr_a}, 32'h0);

    // ---- period 0 on ch2 never expires; one-shot ch1 period 3 ----
    wr(0, 3'd2, 1'b0, 16'd0);
    wr(0, 3'd2, 1'b1, 16'h0001);
    wr(0, 3'd1, 1'b0, 16'd3);
    wr(0, 3'd1, 1'b1, 16'h0003);          // enable one-shot at edge t
    cyc(2);
    check("os_t2", {24'h0, irq_a}, 32'h0);
    cyc(1);
    check("os_t3", {24'h0, irq_a}, 32'h02);
    cyc(20);
    check("os_hold_irq", {24'h0, irq_a}, 32'h02);
    check("os_no_ovr", {28'h0, ovr_a}, 32'h0);

    // ---- PRESCALE=4, ch2 period 2, enable aligned so first tick is 4 edges later ----
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("b_rst", {24'h0, irq_b}, 32'h0);
    wr(1, 3'd2, 1'b0, 16'd2);             // edge 1
    cyc(2);                                // edges 2,3
    wr(1, 3'd2, 1'b1, 16'h0001);          // edge 4 = enable
    cyc(7);
    check("b_t7", {24'h0, irq_b}, 32'h0);
    cyc(1);
    check("b_t8", {24'h0, irq_b}, 32'h04);
    cyc(7);
    check("b_t15_ovr", {28'h0, ovr_b}, 32'h0);
    cyc(1);
    check("b_t16_ovr", {28'h0, ovr_b}, 32'h4);
    check("b_t16_irq", {24'h0, irq_b}, 32'h04);
    ack_b = 4'b0100; cyc(1); ack_b = '0;
    check("b_ack_irq", {24'h0, irq_b}, 32'h0);
    check("b_ack_ovr", {28'h0, ovr_b}, 32'h0);

    // ---- IRQ_BASE=4, periods 3..6, ack held so each expiry shows as a 1-cycle pulse ----
    reset = 1'b1; cyc(1); reset = 1'b0;
    ack_c = 4'hF;
    for (int i = 0; i < 4; i++) wr(2, 3'(i), 1'b0, 16'(3 + i));      // edges 1..4
    for (int i = 0; i < 4; i++) wr(2, 3'(i), 1'b1, 16'h0001);        // edges 5..8
    check("c_e8", {24'h0, irq_c}, {24'h0, exp_c(8)});
    for (int n = 9; n <= 44; n++) begin
      cyc(1);
      check($sformatf("c_e%0d", n), {24'h0, irq_c}, {24'h0, exp_c(n)});
    end
    check("c_ovr", {28'h0, ovr_c}, 32'h0);
    ack_c = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
